// File: rtl/des_key_schedule_if.sv
// Handshake/bus bundle for des_key_schedule: key load, subkey stream and status.
// With PARITY_CHECK_EN defined the bundle also carries parity_err_o.
interface des_key_schedule_if;
    logic [63:0] key_i;
    logic        start_i;
    logic        decrypt_i;
    logic        ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        done_o;
`ifdef PARITY_CHECK_EN
    logic        parity_err_o;

    modport slave (
        input  key_i, start_i, decrypt_i, subkey_ready_i,
        output ready_o, subkey_o, subkey_valid_o, round_o, done_o, parity_err_o
    );
    modport master (
        output key_i, start_i, decrypt_i, subkey_ready_i,
        input  ready_o, subkey_o, subkey_valid_o, round_o, done_o, parity_err_o
    );
`else
    modport slave (
        input  key_i, start_i, decrypt_i, subkey_ready_i,
        output ready_o, subkey_o, subkey_valid_o, round_o, done_o
    );
    modport master (
        output key_i, start_i, decrypt_i, subkey_ready_i,
        input  ready_o, subkey_o, subkey_valid_o, round_o, done_o
    );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one 48-bit subkey per handshake, encrypt (K1..Kn) or decrypt (Kn..K1).
// Optional macro PARITY_CHECK_EN adds a registered odd-parity check of the key at start acceptance.
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    des_key_schedule_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    // idx is the 1-based round number
    function automatic logic [4:0] shift_amt(input logic [4:0] idx);
        case (idx)
            5'd1, 5'd2, 5'd9, 5'd16: return 5'd1;
            default:                 return 5'd2;
        endcase
    endfunction

    function automatic logic [4:0] total_shift();
        int sum;
        sum = 0;
        for (int i = 1; i <= ROUNDS; i++) sum += int'(shift_amt(5'(i)));
        return 5'(sum % 28);
    endfunction

    // Decrypt starts from the last round's C/D, reached by the summed rotation
    localparam logic [4:0] TOTAL_SH = total_shift();

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
        return (x << n) | (x >> (5'd28 - n));
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
        return (x >> n) | (x << (5'd28 - n));
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [4:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [4:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

    // DES bit p (1 = MSB) of the key sits at k[64-p]
    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
                k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
                k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
                k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
                k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
                k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
                k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
                k[43], k[51], k[59], k[36], k[44], k[52], k[60]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] c);
        return {c[42], c[39], c[45], c[32], c[55], c[51],
                c[53], c[28], c[41], c[50], c[35], c[46],
                c[33], c[37], c[44], c[52], c[30], c[48],
                c[40], c[49], c[29], c[36], c[43], c[54],
                c[15], c[4],  c[25], c[19], c[9],  c[1],
                c[26], c[16], c[5],  c[11], c[23], c[8],
                c[12], c[7],  c[17], c[0],  c[22], c[3],
                c[10], c[14], c[6],  c[20], c[27], c[24]};
    endfunction

    state_e      state_q, state_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  round_q, round_d;
    logic        decrypt_q, decrypt_d;
    logic        done_q, done_d;
    logic        last_round;

    assign last_round = decrypt_q ? (round_q == 4'd0) : (round_q == LAST_ROUND);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cd_q      <= '0;
            round_q   <= '0;
            decrypt_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cd_q      <= cd_d;
            round_q   <= round_d;
            decrypt_q <= decrypt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cd_d      = cd_q;
        round_d   = round_q;
        decrypt_d = decrypt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d   = RUN;
                    decrypt_d = bus.decrypt_i;
                    if (bus.decrypt_i) begin
                        cd_d    = rotl_cd(pc1(bus.key_i), TOTAL_SH);
                        round_d = LAST_ROUND;
                    end else begin
                        cd_d    = rotl_cd(pc1(bus.key_i), shift_amt(5'd1));
                        round_d = 4'd0;
                    end
                end
            end
            RUN: begin
                if (bus.subkey_ready_i) begin
                    if (last_round) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (decrypt_q) begin
                        // Undo the rotation that produced the current round
                        cd_d    = rotr_cd(cd_q, shift_amt({1'b0, round_q} + 5'd1));
                        round_d = round_q - 4'd1;
                    end else begin
                        cd_d    = rotl_cd(cd_q, shift_amt({1'b0, round_q} + 5'd2));
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_o        = (state_q == IDLE);
    assign bus.subkey_valid_o = (state_q == RUN);
    assign bus.subkey_o       = (state_q == RUN) ? pc2(cd_q) : 48'd0;
    assign bus.round_o        = round_q;
    assign bus.done_o         = done_q;

`ifdef PARITY_CHECK_EN
    // DES keys carry odd parity per byte; flag any byte with even parity
    function automatic logic key_parity_err(input logic [63:0] k);
        return ~(^k[63:56]) | ~(^k[55:48]) | ~(^k[47:40]) | ~(^k[39:32]) |
               ~(^k[31:24]) | ~(^k[23:16]) | ~(^k[15:8])  | ~(^k[7:0]);
    endfunction

    logic parity_err_q, parity_err_d;

    always_comb begin
        parity_err_d = parity_err_q;
        if (state_q == IDLE && bus.start_i) parity_err_d = key_parity_err(bus.key_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_err_d;
    end

    assign bus.parity_err_o = parity_err_q;
`endif

endmodule
